// File: rtl/secded_codec_pipe.sv
// Pipelined Hamming SECDED channel: encode, XOR noise mask, decode, classify.
// Ports: i_clk/i_rst, in i_valid/o_ready/i_data/i_noise, out o_valid/i_ready/o_data,
//        o_syndrome/error flags, i_cnt_clr and saturating counters o_cnt_*.
module secded_codec_pipe #(
    parameter  int DATA_W = 4,
    parameter  int PAR_W  = 3,
    parameter  int CNT_W  = 16,
    localparam int CW_W   = DATA_W + PAR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CW_W-1:0]   i_noise,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [PAR_W-1:0]  o_syndrome,
    output logic              o_1bit_error,
    output logic              o_2bit_error,
    output logic              o_parity_error,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_cnt_1bit,
    output logic [CNT_W-1:0]  o_cnt_2bit,
    output logic [CNT_W-1:0]  o_cnt_par
);

    localparam int N = DATA_W + PAR_W;

    function automatic logic [CW_W-1:0] enc(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        int              di;
        cw = '0;
        di = 0;
        for (int k = 1; k <= N; k++) begin
            if ((k & (k - 1)) != 0) begin
                cw[k] = d[di];
                di++;
            end
        end
        // Parity slots are still zero here, so XOR over all positions is safe.
        for (int j = 0; j < PAR_W; j++) begin
            for (int k = 1; k <= N; k++) begin
                if ((k & (1 << j)) != 0 && k != (1 << j))
                    cw[1 << j] = cw[1 << j] ^ cw[k];
            end
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        int                di;
        d  = '0;
        di = 0;
        for (int k = 1; k <= N; k++) begin
            if ((k & (k - 1)) != 0) begin
                d[di] = cw[k];
                di++;
            end
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic              r_s1_valid;
    logic [CW_W-1:0]   r_s1_cw;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic [PAR_W-1:0]  r_s2_syn;
    logic              r_s2_f1;
    logic              r_s2_f2;
    logic              r_s2_fp;
    logic [CNT_W-1:0]  r_cnt_1;
    logic [CNT_W-1:0]  r_cnt_2;
    logic [CNT_W-1:0]  r_cnt_p;

    logic              w_s2_en;
    logic              w_s1_en;
    logic              w_xfer;
    logic [PAR_W-1:0]  w_syn;
    logic              w_par;
    logic              w_in_rng;
    logic [CW_W-1:0]   w_fix;
    logic              w_f1;
    logic              w_f2;
    logic              w_fp;

    // Stage 2 frees up when empty or draining; stage 1 follows it.
    assign w_s2_en = !r_s2_valid || i_ready;
    assign w_s1_en = !r_s1_valid || w_s2_en;
    assign o_ready = w_s1_en;
    assign w_xfer  = r_s2_valid && i_ready;

    always_comb begin
        w_syn = '0;
        for (int k = 1; k <= N; k++) begin
            if (r_s1_cw[k])
                w_syn = w_syn ^ PAR_W'(k);
        end
        w_par    = ^r_s1_cw;
        w_in_rng = int'(w_syn) <= N;
        w_fix    = r_s1_cw;
        w_f1     = 1'b0;
        w_f2     = 1'b0;
        w_fp     = 1'b0;
        unique case (1'b1)
            (w_syn != '0 && w_par && w_in_rng): begin
                w_fix[w_syn] = ~r_s1_cw[w_syn];
                w_f1         = 1'b1;
            end
            (w_syn != '0 && !(w_par && w_in_rng)): w_f2 = 1'b1;
            (w_syn == '0 && w_par):                w_fp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_syn   <= '0;
            r_s2_f1    <= 1'b0;
            r_s2_f2    <= 1'b0;
            r_s2_fp    <= 1'b0;
        end else begin
            if (w_s1_en) begin
                r_s1_valid <= i_valid;
                r_s1_cw    <= i_valid ? (enc(i_data) ^ i_noise) : '0;
            end
            // Bubbles load zeros so flags/syndrome read 0 while o_valid=0.
            if (w_s2_en) begin
                r_s2_valid <= r_s1_valid;
                r_s2_data  <= r_s1_valid ? extract(w_fix) : '0;
                r_s2_syn   <= r_s1_valid ? w_syn : '0;
                r_s2_f1    <= r_s1_valid && w_f1;
                r_s2_f2    <= r_s1_valid && w_f2;
                r_s2_fp    <= r_s1_valid && w_fp;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt_1 <= '0;
            r_cnt_2 <= '0;
            r_cnt_p <= '0;
        end else if (i_cnt_clr) begin
            r_cnt_1 <= '0;
            r_cnt_2 <= '0;
            r_cnt_p <= '0;
        end else if (w_xfer) begin
            if (r_s2_f1) r_cnt_1 <= bump(r_cnt_1);
            if (r_s2_f2) r_cnt_2 <= bump(r_cnt_2);
            if (r_s2_fp) r_cnt_p <= bump(r_cnt_p);
        end
    end

    assign o_valid        = r_s2_valid;
    assign o_data         = r_s2_data;
    assign o_syndrome     = r_s2_syn;
    assign o_1bit_error   = r_s2_f1;
    assign o_2bit_error   = r_s2_f2;
    assign o_parity_error = r_s2_fp;
    assign o_cnt_1bit     = r_cnt_1;
    assign o_cnt_2bit     = r_cnt_2;
    assign o_cnt_par      = r_cnt_p;

endmodule

// File: tb/tb_secded_codec_pipe.sv
// Directed bench for secded_codec_pipe (DATA_W=4, PAR_W=3, CNT_W=2).
// Covers encode/decode classes, backpressure streaming, saturation, clear, reset.
module tb_secded_codec_pipe;

    logic       clk;
    logic       rst;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_data;
    logic [7:0] i_noise;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_data;
    logic [2:0] o_syndrome;
    logic       o_1bit_error;
    logic       o_2bit_error;
    logic       o_parity_error;
    logic       i_cnt_clr;
    logic [1:0] o_cnt_1bit;
    logic [1:0] o_cnt_2bit;
    logic [1:0] o_cnt_par;

    int n_vec;
    int n_bad;

    secded_codec_pipe #(.DATA_W(4), .PAR_W(3), .CNT_W(2)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .i_noise       (i_noise),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_syndrome    (o_syndrome),
        .o_1bit_error  (o_1bit_error),
        .o_2bit_error  (o_2bit_error),
        .o_parity_error(o_parity_error),
        .i_cnt_clr     (i_cnt_clr),
        .o_cnt_1bit    (o_cnt_1bit),
        .o_cnt_2bit    (o_cnt_2bit),
        .o_cnt_par     (o_cnt_par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ov();
        int t;
        t = 0;
        while (!o_valid && t < 8) begin
            @(posedge clk); #1;
            t++;
        end
        chk("o_valid_timeout", 64'(t < 8), 64'd1);
    endtask

    // Called #1 after an edge; returns #1 after the output transfer edge.
    task automatic xfer(input string tag, input logic [3:0] d,
                        input logic [7:0] n, input logic [3:0] ed,
                        input logic [2:0] es, input logic [2:0] ef,
                        input logic clr);
        i_valid = 1'b1;
        i_data  = d;
        i_noise = n;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk({tag, "_lat"}, 64'(o_valid), 64'd0);
        wait_ov();
        chk({tag, "_data"}, 64'(o_data), 64'(ed));
        chk({tag, "_syn"}, 64'(o_syndrome), 64'(es));
        chk({tag, "_flags"},
            64'({o_1bit_error, o_2bit_error, o_parity_error}), 64'(ef));
        i_cnt_clr = clr;
        @(posedge clk); #1;
        i_cnt_clr = 1'b0;
    endtask

    logic [3:0] exp_q[$];
    logic [3:0] held;
    logic       hold;
    int         sent;
    int         rcv;
    int         cyc;
    int         seen;

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_data    = '0;
        i_noise   = '0;
        i_ready   = 1'b1;
        i_cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_ready", 64'(o_ready), 64'd1);
        chk("rst_o_data", 64'(o_data), 64'd0);
        chk("rst_syn", 64'(o_syndrome), 64'd0);
        chk("rst_flags",
            64'({o_1bit_error, o_2bit_error, o_parity_error}), 64'd0);
        chk("rst_cnts", 64'({o_cnt_1bit, o_cnt_2bit, o_cnt_par}), 64'd0);

        xfer("clean", 4'b1011, 8'h00, 4'b1011, 3'd0, 3'b000, 1'b0);
        chk("clean_cnts", 64'({o_cnt_1bit, o_cnt_2bit, o_cnt_par}), 64'd0);

        xfer("pos5", 4'b1011, 8'h20, 4'b1011, 3'd5, 3'b100, 1'b0);
        chk("pos5_cnt1", 64'(o_cnt_1bit), 64'd1);

        xfer("pos5_1", 4'b1011, 8'h22, 4'b1001, 3'd4, 3'b010, 1'b0);
        chk("pos5_1_cnt2", 64'(o_cnt_2bit), 64'd1);

        xfer("ovpar", 4'b1011, 8'h01, 4'b1011, 3'd0, 3'b001, 1'b0);
        chk("ovpar_cntp", 64'(o_cnt_par), 64'd1);

        // 0110 encodes to 8'h66; pos7 flip is correctable.
        xfer("pos7", 4'b0110, 8'h80, 4'b0110, 3'd7, 3'b100, 1'b0);
        chk("pos7_cnt1", 64'(o_cnt_1bit), 64'd2);

        // pos7 + overall parity: double error, raw data has d3 flipped.
        xfer("pos7_0", 4'b0110, 8'h81, 4'b1110, 3'd7, 3'b010, 1'b0);
        chk("pos7_0_cnt2", 64'(o_cnt_2bit), 64'd2);

        // Backpressure stream.
        sent = 0;
        rcv  = 0;
        cyc  = 0;
        hold = 1'b0;
        held = '0;
        i_noise = '0;
        while (rcv < 8 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (hold) begin
                chk("stall_valid", 64'(o_valid), 64'd1);
                chk("stall_data", 64'(o_data), 64'(held));
            end
            i_ready = 1'($urandom_range(0, 1));
            i_valid = (sent < 8);
            i_data  = 4'((sent * 5 + 2) & 15);
            #1;
            if (i_valid && o_ready) begin
                exp_q.push_back(i_data);
                sent++;
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() > 0)
                    chk("stream_data", 64'(o_data), 64'(exp_q.pop_front()));
                else
                    chk("stream_extra", 64'd1, 64'd0);
                chk("stream_flags",
                    64'({o_1bit_error, o_2bit_error, o_parity_error}), 64'd0);
                rcv++;
            end
            hold = o_valid && !i_ready;
            held = o_data;
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("stream_count", 64'(rcv), 64'd8);
        chk("stream_sent", 64'(sent), 64'd8);

        // Saturation: cnt1 starts at 2.
        for (int i = 0; i < 5; i++) begin
            xfer("sat", 4'(i + 1), 8'(1 << (i + 1)), 4'(i + 1),
                 3'(i + 1), 3'b100, 1'b0);
            chk("sat_cnt1", 64'(o_cnt_1bit), 64'd3);
        end

        xfer("clr", 4'hA, 8'h40, 4'hA, 3'd6, 3'b100, 1'b1);
        chk("clr_cnts", 64'({o_cnt_1bit, o_cnt_2bit, o_cnt_par}), 64'd0);

        xfer("par2", 4'h5, 8'h01, 4'h5, 3'd0, 3'b001, 1'b0);
        chk("par2_cntp", 64'(o_cnt_par), 64'd1);

        // Reset with both stages full and output stalled.
        i_valid = 1'b1;
        i_data  = 4'h3;
        i_noise = 8'h00;
        @(posedge clk); #1;
        i_data = 4'h5;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("pre_rst_valid", 64'(o_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_cntp", 64'(o_cnt_par), 64'd0);
        chk("mid_rst_data", 64'(o_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        i_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        chk("post_rst_stale", 64'(seen), 64'd0);
        chk("post_rst_ready", 64'(o_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/secded_codec_pipe.md
Name: secded_codec_pipe

Overview:
Parametrised, pipelined Hamming SECDED encode/inject/decode channel for any data width. It replaces the fixed 4-bit combinational chain with a streaming block that has valid/ready handshakes on both sides and a per-transaction noise mask. It also keeps saturating error-statistics counters. The block sits between a data source and a consumer, and serves as the bench/demo vehicle for ECC characterisation.

Parameters:
DATA_W, 4, data bits per word (1..64)
PAR_W, 3, Hamming parity bits; smallest r with 2^r >= DATA_W+r+1 (user-set; out-of-range values are illegal)
CW_W, DATA_W+PAR_W+1, codeword width including overall parity (derived localparam)
CNT_W, 16, width of each error counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_valid  in  1  input word valid
o_ready  out  1  block can accept input this cycle
i_data  in  DATA_W  data word to protect
i_noise  in  CW_W  error mask XORed onto the codeword; sampled with i_data
o_valid  out  1  output word valid
i_ready  in  1  consumer accepts output this cycle
o_data  out  DATA_W  decoded (corrected where possible) data
o_syndrome  out  PAR_W  Hamming syndrome of the received word
o_1bit_error  out  1  single error in a Hamming position, corrected
o_2bit_error  out  1  uncorrectable error detected
o_parity_error  out  1  error confined to the overall parity bit
i_cnt_clr  in  1  synchronous clear of all counters
o_cnt_1bit  out  CNT_W  count of o_1bit_error words delivered
o_cnt_2bit  out  CNT_W  count of o_2bit_error words delivered
o_cnt_par  out  CNT_W  count of o_parity_error words delivered

Behaviour:
- Codeword layout: cw[0] is the overall parity (XOR of cw[N:1], N=DATA_W+PAR_W).
  - cw[k] for k=1..N holds Hamming position k.
  - Power-of-two positions carry parity bits; the other positions carry data bits LSB-first in ascending position order.
  - Parity bit at position 2^j is the XOR of all data positions whose index has bit j set.
- Stage 1 (encode): on an accepted input (i_valid & o_ready), register cw ^ i_noise.
- Stage 2 (decode): register the decode of the stage-1 word.
  - Syndrome s = XOR of indices of set bits in positions 1..N.
  - p = XOR of all CW_W received bits.
- Classification:
  - s=0, p=0: no error.
  - s!=0, p=1, s<=N: flip position s, assert o_1bit_error.
  - s!=0, p=1, s>N: assert o_2bit_error.
  - s=0, p=1: assert o_parity_error; data is unaltered.
  - s!=0, p=0: assert o_2bit_error; o_data is the raw extracted data.
  - At most one flag is high per word.
- Latency: 2 cycles from input acceptance to o_valid with no backpressure. Throughput is 1 word/cycle.
- Handshake:
  - A transfer occurs when valid & ready are both high on a rising edge.
  - o_valid with its o_data, o_syndrome and flags holds stable until i_ready.
  - o_ready = !(stage1 full & stage2 full & !i_ready), i.e. the pipeline advances whenever the downstream stage is empty or draining.
  - o_ready may depend combinationally on i_ready. o_valid must not depend on i_valid.
- Flags and o_syndrome are meaningful only while o_valid=1 and are driven to 0 when o_valid=0.
- Counters:
  - Each counter increments by 1 on an output transfer carrying its flag.
  - Counters saturate at all-ones.
  - i_cnt_clr takes priority over an increment in the same cycle; the result is 0.
- Reset (async assert, sync-safe release):
  - Both stages are empty; o_valid=0 and all flags are 0.
  - o_data=0, o_syndrome=0, counters=0.
  - o_ready=1 from the first cycle after reset deassertion.
- Reset mid-transfer: in-flight words are discarded, not delivered. Counters are cleared.
- i_noise with more than 2 bits set: the decode result is whatever the classification above yields. No extra detection is performed.

Test Plan:
1. DATA_W=4, i_data=4'b1011, i_noise=0 -> codeword 8'hAA internally. Two cycles later: o_data=4'b1011, o_syndrome=0, all flags 0, counters unchanged.
2. i_data=4'b1011, i_noise=8'h20 (pos5) -> o_syndrome=3'd5, o_1bit_error=1, o_data=4'b1011; o_cnt_1bit increments to 1.
3. i_data=4'b1011, i_noise=8'h22 (pos5, pos1) -> o_syndrome=3'd4, o_2bit_error=1, o_data=raw 4'b1001; o_cnt_2bit=1.
4. i_noise=8'h01 -> o_parity_error=1, o_syndrome=0, o_data=input data; o_cnt_par=1.
5. Stream 8 back-to-back words with i_ready toggled low randomly -> no word lost or duplicated; output order matches input; outputs are stable while i_ready=0.
6. CNT_W=2, drive 5 single-error words -> o_cnt_1bit saturates at 3. Assert i_cnt_clr together with a 6th error word -> count=0. Assert i_rst mid-stream -> o_valid=0 immediately and no stale word appears after release.
